// File: rtl/train_step_ctrl.sv
// Step-handshake initiator for one training layer: zero_grad/forward, pipelined forward+backward, last backward, update.
// Optional update timeout and sticky upd_timeout flag are enabled by defining TRAIN_CTRL_UPD_TIMEOUT_EN.
module train_step_ctrl #(
  parameter int BATCH_SIZE  = 2,
  parameter int STATE_LEN   = 4,
  parameter int F_CODE      = 0,
  parameter int B_CODE      = 0,
  parameter int UPD_TIMEOUT = 1024,
  localparam int IDX_W      = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [STATE_LEN-1:0] state_forward,
  output logic [STATE_LEN-1:0] state_backward,
  output logic                 zero_grad,
  output logic                 run_forward,
  output logic                 run_backward,
  output logic                 load_backward,
  output logic                 update,
  output logic [IDX_W-1:0]     fwd_idx,
  output logic [IDX_W-1:0]     bwd_idx,
  input  logic                 valid_zero_grad,
  input  logic                 valid_forward,
  input  logic                 valid_backward,
  input  logic                 valid_update
`ifdef TRAIN_CTRL_UPD_TIMEOUT_EN
  , output logic               upd_timeout
`endif
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    S1       = 4'd1,
    S1_REL   = 4'd2,
    LOAD     = 4'd3,
    STEP     = 4'd4,
    STEP_REL = 4'd5,
    LLOAD    = 4'd6,
    LAST     = 4'd7,
    LAST_REL = 4'd8,
    UPD      = 4'd9,
    UPD_REL  = 4'd10,
    DONE     = 4'd11
  } state_t;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BATCH_SIZE - 1);
  localparam logic [STATE_LEN-1:0] F_VAL    = STATE_LEN'(F_CODE);
  localparam logic [STATE_LEN-1:0] B_VAL    = STATE_LEN'(B_CODE);

`ifdef TRAIN_CTRL_UPD_TIMEOUT_EN
  localparam int TO_W = (UPD_TIMEOUT > 1) ? $clog2(UPD_TIMEOUT) : 1;
  logic [TO_W-1:0] upd_cnt_r;
`endif

  state_t state_r;

  // Step sequencer: fwd_idx doubles as the pipeline step counter k, so bwd_idx is simply its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      state_forward  <= {STATE_LEN{1'b0}};
      state_backward <= {STATE_LEN{1'b0}};
      zero_grad      <= 1'b0;
      run_forward    <= 1'b0;
      run_backward   <= 1'b0;
      load_backward  <= 1'b0;
      update         <= 1'b0;
      fwd_idx        <= {IDX_W{1'b0}};
      bwd_idx        <= {IDX_W{1'b0}};
`ifdef TRAIN_CTRL_UPD_TIMEOUT_EN
      upd_cnt_r      <= {TO_W{1'b0}};
      upd_timeout    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r        <= S1;
            busy           <= 1'b1;
            state_forward  <= F_VAL;
            state_backward <= B_VAL;
            zero_grad      <= 1'b1;
            run_forward    <= 1'b1;
            fwd_idx        <= {IDX_W{1'b0}};
`ifdef TRAIN_CTRL_UPD_TIMEOUT_EN
            upd_timeout    <= 1'b0;
`endif
          end
        end
        S1: begin
          if (valid_forward && valid_zero_grad) begin
            zero_grad   <= 1'b0;
            run_forward <= 1'b0;
            state_r     <= S1_REL;
          end
        end
        S1_REL: begin
          if (!valid_forward && !valid_zero_grad) begin
            load_backward <= 1'b1;
            state_r       <= (BATCH_SIZE > 1) ? LOAD : LLOAD;
          end
        end
        LOAD: begin
          load_backward <= 1'b0;
          run_forward   <= 1'b1;
          run_backward  <= 1'b1;
          fwd_idx       <= fwd_idx + IDX_W'(1);
          bwd_idx       <= fwd_idx;
          state_r       <= STEP;
        end
        STEP: begin
          if (valid_forward && valid_backward) begin
            run_forward  <= 1'b0;
            run_backward <= 1'b0;
            state_r      <= STEP_REL;
          end
        end
        STEP_REL: begin
          if (!valid_forward && !valid_backward) begin
            load_backward <= 1'b1;
            state_r       <= (fwd_idx < LAST_IDX) ? LOAD : LLOAD;
          end
        end
        LLOAD: begin
          load_backward <= 1'b0;
          run_backward  <= 1'b1;
          bwd_idx       <= LAST_IDX;
          state_r       <= LAST;
        end
        LAST: begin
          if (valid_backward) begin
            run_backward <= 1'b0;
            state_r      <= LAST_REL;
          end
        end
        LAST_REL: begin
          if (!valid_backward) begin
            update  <= 1'b1;
            state_r <= UPD;
`ifdef TRAIN_CTRL_UPD_TIMEOUT_EN
            upd_cnt_r <= {TO_W{1'b0}};
`endif
          end
        end
        UPD: begin
          if (valid_update) begin
            update  <= 1'b0;
            state_r <= UPD_REL;
`ifdef TRAIN_CTRL_UPD_TIMEOUT_EN
          end else if (upd_cnt_r == TO_W'(UPD_TIMEOUT - 1)) begin
            // Layer never answered: abandon the update and close the batch.
            update         <= 1'b0;
            upd_timeout    <= 1'b1;
            done           <= 1'b1;
            busy           <= 1'b0;
            state_forward  <= {STATE_LEN{1'b0}};
            state_backward <= {STATE_LEN{1'b0}};
            state_r        <= DONE;
          end else begin
            upd_cnt_r <= upd_cnt_r + TO_W'(1);
`endif
          end
        end
        UPD_REL: begin
          if (!valid_update) begin
            done           <= 1'b1;
            busy           <= 1'b0;
            state_forward  <= {STATE_LEN{1'b0}};
            state_backward <= {STATE_LEN{1'b0}};
            state_r        <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r        <= IDLE;
          busy           <= 1'b0;
          done           <= 1'b0;
          state_forward  <= {STATE_LEN{1'b0}};
          state_backward <= {STATE_LEN{1'b0}};
          zero_grad      <= 1'b0;
          run_forward    <= 1'b0;
          run_backward   <= 1'b0;
          load_backward  <= 1'b0;
          update         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/train_step_ctrl.md
Name: train_step_ctrl

Overview:
- Initiator for a training layer's step handshake. Issues zero_grad, run_forward, run_backward, load_backward and update in the fixed per-batch pipeline order, and waits on each valid_* acknowledge.
- Drives the batch indices that select forward and backward input data.
- Sits between the top-level training sequencer (start/done) and one layer instance.

Parameters:
- BATCH_SIZE, 2, samples per batch; must be >= 1.
- STATE_LEN, 4, width of the state_* codes; matches `STATE_LEN.
- F_CODE, 0, state_forward value driven while busy.
- B_CODE, 0, state_backward value driven while busy.
- UPD_TIMEOUT, 1024, update timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one batch
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the batch completes
- state_forward  out  STATE_LEN  F_CODE while busy, else 0
- state_backward  out  STATE_LEN  B_CODE while busy, else 0
- zero_grad  out  1  zero-gradient request
- run_forward  out  1  forward request
- run_backward  out  1  backward request
- load_backward  out  1  one-cycle pulse before every backward step
- update  out  1  parameter update request
- fwd_idx  out  max(1,$clog2(BATCH_SIZE))  sample index for d_forward
- bwd_idx  out  max(1,$clog2(BATCH_SIZE))  sample index for d_backward
- valid_zero_grad, valid_forward, valid_backward, valid_update  in  1 each  layer acknowledges

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-operation: all outputs drop to 0 immediately and the FSM returns to IDLE. No done pulse is generated.
- Handshake (4-phase): the request is held high until every acknowledge for the current step is sampled high on the same edge. The requests drop on that edge. The FSM then waits in a REL state until all of those acknowledges are low, and only then starts the next step.
- Combined steps: run_forward and run_backward rise together and fall together. Both are held until valid_forward & valid_backward.
- FSM states: IDLE, S1, S1_REL, LOAD, STEP, STEP_REL, LLOAD, LAST, LAST_REL, UPD, UPD_REL, DONE.
- IDLE: start=1 goes to S1. The next cycle has busy=1, zero_grad=1, run_forward=1, fwd_idx=0.
- S1: acknowledge condition is valid_forward & valid_zero_grad. zero_grad and run_forward drop together.
- S1_REL → LOAD when BATCH_SIZE > 1, otherwise → LLOAD.
- LOAD: load_backward=1 for exactly one cycle.
- STEP: entered on the next cycle. run_forward=1 with fwd_idx=k; run_backward=1 with bwd_idx=k-1, for k = 1..BATCH_SIZE-1. After STEP_REL, go to LOAD if k < BATCH_SIZE-1, otherwise to LLOAD.
- LLOAD / LAST: one-cycle load_backward, then run_backward alone with bwd_idx = BATCH_SIZE-1.
- UPD: update=1 until valid_update is seen. UPD_REL waits for valid_update=0.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Index hold: indices keep their value after a step ends and change only when the next step is issued.
- start while busy or in DONE: ignored.
- Acknowledges high before a request: ignored. An acknowledge counts only while the corresponding request is high.

Optional Feature:
- Macro: TRAIN_CTRL_UPD_TIMEOUT_EN.
- Defined: a counter starts when UPD is entered. If valid_update is still low after UPD_TIMEOUT cycles, update drops, a sticky output upd_timeout (1 bit, reset 0, cleared on the next accepted start) is set, and the FSM goes straight to DONE.
- Not defined: the upd_timeout port and the counter are absent, and UPD waits indefinitely.

Test Plan:
- BATCH_SIZE=2, responder acks 3 cycles after each request rises and drops its ack 1 cycle after the request falls -> output order: zero_grad+run_forward(fwd_idx 0); load_backward pulse; run_forward(fwd_idx 1)+run_backward(bwd_idx 0); load_backward; run_backward(bwd_idx 1); update; done once.
- Combined step with valid_forward at cycle 2 and valid_backward at cycle 9 -> both runs stay high until cycle 9 and fall together.
- Responder holds its ack high for 5 extra cycles -> no new request is issued until all acks are low.
- BATCH_SIZE=1 -> S1, then load_backward, run_backward(bwd_idx 0), update, done. run_backward never overlaps run_forward.
- rst_n pulsed low during STEP -> all outputs 0 asynchronously. A new start after release begins again at S1 with fwd_idx=0.
- With TRAIN_CTRL_UPD_TIMEOUT_EN and UPD_TIMEOUT=16, valid_update never asserted -> update falls after 16 cycles, upd_timeout=1, done pulses; the next start clears upd_timeout.
